packed_frame_serializer: RTL and testbench

- Downstream consumer of a packed 3-D frame `logic [OUTER-1:0][INNER-1:0][NIBBLE_W-1:0]`.
- Accepts one whole frame per valid/ready handshake and emits its elements one per handshake, inner index fastest, as an index-tagged stream.
- Holds one active frame and one pending frame, so back-to-back frames stream with no bubble.

---
 rtl/packed_frame_serializer_if.sv | 40 ++++
 rtl/packed_frame_serializer.sv | 140 ++++++++++++++
 tb/tb_packed_frame_serializer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/packed_frame_serializer_if.sv
// ============================================================================
// packed_frame_serializer_if : frame-in / element-out bus for the serializer
// Rev 1.0
// ============================================================================
`default_nettype none

interface packed_frame_serializer_if #(
    parameter int NIBBLE_W = 4,
    parameter int OUTER    = 2,
    parameter int INNER    = 3
);
    localparam int c_OW = (OUTER > 1) ? $clog2(OUTER) : 1;
    localparam int c_IW = (INNER > 1) ? $clog2(INNER) : 1;

    logic [OUTER-1:0][INNER-1:0][NIBBLE_W-1:0] in_frame;
    logic                                      in_valid;
    logic                                      in_ready;
    logic [NIBBLE_W-1:0]                       out_data;
    logic                                      out_valid;
    logic                                      out_ready;
    logic [c_OW-1:0]                           out_outer_idx;
    logic [c_IW-1:0]                           out_inner_idx;
    logic                                      out_first;
    logic                                      out_last;
    logic [7:0]                                frames_done;

    modport slave (
        input  in_frame, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_outer_idx, out_inner_idx,
               out_first, out_last, frames_done
    );

    modport master (
        output in_frame, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_outer_idx, out_inner_idx,
               out_first, out_last, frames_done
    );
endinterface

`default_nettype wire

// File: rtl/packed_frame_serializer.sv
// ============================================================================
// packed_frame_serializer : accepts whole packed frames, emits elements in order
// Rev 1.0
// ============================================================================
`default_nettype none

module packed_frame_serializer #(
    parameter int NIBBLE_W = 4,
    parameter int OUTER    = 2,
    parameter int INNER    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    packed_frame_serializer_if.slave bus
);
    localparam int c_OW = (OUTER > 1) ? $clog2(OUTER) : 1;
    localparam int c_IW = (INNER > 1) ? $clog2(INNER) : 1;
    localparam int c_FW = OUTER * INNER * NIBBLE_W;
    localparam logic [c_OW-1:0] c_OUTER_MAX = c_OW'(OUTER - 1);
    localparam logic [c_IW-1:0] c_INNER_MAX = c_IW'(INNER - 1);

    typedef logic [c_FW-1:0] frame_t;
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_EMIT = 1'b1} state_t;

    state_t              state_q;
    frame_t              active_q;
    frame_t              pend_q;
    logic                pend_full_q;
    logic [c_OW-1:0]     outer_q;
    logic [c_IW-1:0]     inner_q;
    logic [NIBBLE_W-1:0] data_q;
    logic                first_q;
    logic                last_q;
    logic [7:0]          done_q;

    logic                w_in_xfer;
    logic                w_out_xfer;
    logic                w_end_xfer;
    logic                w_start;
    logic                w_to_pend;
    logic                w_step;
    frame_t              w_in_frame;
    frame_t              w_src;
    logic [c_OW-1:0]     outer_d;
    logic [c_IW-1:0]     inner_d;

    function automatic logic [NIBBLE_W-1:0] elem(frame_t f, logic [c_OW-1:0] o,
                                                 logic [c_IW-1:0] i);
        int k;
        k = int'(o) * INNER + int'(i);
        return f[k*NIBBLE_W +: NIBBLE_W];
    endfunction

    assign w_in_frame   = bus.in_frame;
    assign bus.in_ready = !pend_full_q;
    assign w_in_xfer    = bus.in_valid && !pend_full_q;
    assign w_out_xfer   = (state_q == ST_EMIT) && bus.out_ready;
    assign w_end_xfer   = w_out_xfer && last_q;
    // An input arriving while the active frame keeps going parks in pending
    assign w_to_pend    = w_in_xfer && (state_q == ST_EMIT) && !w_end_xfer;

    always_comb begin
        w_start = 1'b0;
        w_src   = active_q;
        if (state_q == ST_IDLE) begin
            w_start = w_in_xfer;
            w_src   = w_in_frame;
        end else if (w_end_xfer) begin
            if (pend_full_q) begin
                w_start = 1'b1;
                w_src   = pend_q;
            end else if (w_in_xfer) begin
                w_start = 1'b1;
                w_src   = w_in_frame;
            end
        end
    end

    assign w_step = w_start || (w_out_xfer && !last_q);

    always_comb begin
        outer_d = outer_q;
        inner_d = inner_q;
        if (w_start) begin
            outer_d = '0;
            inner_d = '0;
        end else if (inner_q == c_INNER_MAX) begin
            inner_d = '0;
            outer_d = outer_q + 1'b1;
        end else begin
            inner_d = inner_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            active_q    <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            outer_q     <= '0;
            inner_q     <= '0;
            data_q      <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: if (w_start) state_q <= ST_EMIT;
                ST_EMIT: if (w_end_xfer && !w_start) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
            if (w_start) active_q <= w_src;
            if (w_to_pend) begin
                pend_q      <= w_in_frame;
                pend_full_q <= 1'b1;
            end else if (w_end_xfer) begin
                pend_full_q <= 1'b0;
            end
            if (w_end_xfer) done_q <= done_q + 8'd1;
            if (w_step) begin
                outer_q <= outer_d;
                inner_q <= inner_d;
                data_q  <= elem(w_src, outer_d, inner_d);
                first_q <= (outer_d == '0) && (inner_d == '0);
                last_q  <= (outer_d == c_OUTER_MAX) && (inner_d == c_INNER_MAX);
            end
        end
    end

    assign bus.out_valid     = (state_q == ST_EMIT);
    assign bus.out_data      = data_q;
    assign bus.out_outer_idx = outer_q;
    assign bus.out_inner_idx = inner_q;
    assign bus.out_first     = first_q;
    assign bus.out_last      = last_q;
    assign bus.frames_done   = done_q;
endmodule

`default_nettype wire

// File: tb/tb_packed_frame_serializer.sv
// ============================================================================
// tb_packed_frame_serializer : randomized bench with element-queue reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_packed_frame_serializer;
    localparam int NW  = 4;
    localparam int OU  = 2;
    localparam int IN  = 3;
    localparam int NEL = OU * IN;
    localparam int FW  = NEL * NW;
    localparam int OW  = 1;
    localparam int IW  = 2;
    localparam int EW  = NW + OW + IW + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    packed_frame_serializer_if #(.NIBBLE_W(NW), .OUTER(OU), .INNER(IN)) bus0 ();
    packed_frame_serializer_if #(.NIBBLE_W(NW), .OUTER(1),  .INNER(1))  bus1 ();

    packed_frame_serializer #(.NIBBLE_W(NW), .OUTER(OU), .INNER(IN)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    packed_frame_serializer #(.NIBBLE_W(NW), .OUTER(1), .INNER(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: every accepted frame expands into its element sequence
    logic [EW-1:0] expq[$];
    int            held     = 0;
    int            done_cnt = 0;
    int            ready_mode = 0;
    int            ph = 0;
    logic [EW-1:0] obs;
    logic [FW-1:0] fa, fb;
    logic [3:0]    f1;

    assign obs = {bus0.out_data, bus0.out_outer_idx, bus0.out_inner_idx,
                  bus0.out_first, bus0.out_last};

    function automatic logic [EW-1:0] mk_elem(input logic [FW-1:0] f, input int k);
        int d, o, i, v;
        d = int'(f >> (k * NW)) & ((1 << NW) - 1);
        o = k / IN;
        i = k % IN;
        v = (((d << OW) | o) << IW) | i;
        v = (v << 2) | ((k == 0) ? 2 : 0) | ((k == NEL - 1) ? 1 : 0);
        return EW'(v);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", 32'(bus0.in_ready), 32'(held < 2));
            chk("out_valid", 32'(bus0.out_valid), 32'(held > 0));
            chk("frames_done", 32'(bus0.frames_done), 32'(done_cnt));
            if (bus0.out_valid) begin
                if (expq.size() == 0) chk("spurious_elem", 32'(obs), 32'(0) - 1);
                else                  chk("elem", 32'(obs), 32'(expq[0]));
            end
            if (bus0.out_valid && bus0.out_ready && expq.size() > 0) begin
                if (expq[0][0]) begin
                    held--;
                    done_cnt = (done_cnt + 1) % 256;
                end
                void'(expq.pop_front());
            end
            if (bus0.in_valid && bus0.in_ready) begin
                for (int k = 0; k < NEL; k++) expq.push_back(mk_elem(bus0.in_frame, k));
                held++;
            end
        end
    end

    initial begin
        bus0.out_ready = 1'b1;
        bus1.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: begin
                    bus0.out_ready = (ph == 0);
                    ph = (ph + 1) % 3;
                end
                2:       bus0.out_ready = 1'($urandom_range(0, 1));
                default: bus0.out_ready = 1'b1;
            endcase
        end
    end

    task automatic send_frame(input logic [FW-1:0] f);
        int   n;
        logic acc;
        n = 0;
        bus0.in_frame = f;
        bus0.in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = bus0.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        chk("accept_timeout", 32'(acc), 32'd1);
        bus0.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (held != 0 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", 32'(held), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus0.in_valid = 1'b0;
        bus0.in_frame = '0;
        bus1.in_valid = 1'b0;
        bus1.in_frame = '0;
        #2;
        chk("rst_out_valid", 32'(bus0.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus0.out_data), 32'd0);
        chk("rst_outer_idx", 32'(bus0.out_outer_idx), 32'd0);
        chk("rst_inner_idx", 32'(bus0.out_inner_idx), 32'd0);
        chk("rst_first", 32'(bus0.out_first), 32'd0);
        chk("rst_last", 32'(bus0.out_last), 32'd0);
        chk("rst_frames_done", 32'(bus0.frames_done), 32'd0);
        chk("rst_in_ready", 32'(bus0.in_ready), 32'd1);
        #21 rst = 1'b0;
        @(posedge clk);
        #1;

        // single frame
        send_frame(24'h6E56E5);
        drain();
        chk("t1_done", 32'(bus0.frames_done), 32'd1);

        // back-to-back frames, second one parks in pending
        send_frame(24'h6E56E5);
        send_frame(24'h123456);
        chk("t2_pend_ready", 32'(bus0.in_ready), 32'd0);
        drain();
        chk("t2_done", 32'(bus0.frames_done), 32'd3);

        // stalled output
        ready_mode = 1;
        send_frame(FW'($urandom));
        send_frame(FW'($urandom));
        drain();
        ready_mode = 0;
        @(posedge clk);
        #1;

        // new frame accepted on the same edge as the last element leaves
        fa = FW'($urandom);
        fb = FW'($urandom);
        send_frame(fa);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        send_frame(fb);
        chk("t4_valid", 32'(bus0.out_valid), 32'd1);
        chk("t4_first", 32'(bus0.out_first), 32'd1);
        chk("t4_data", 32'(bus0.out_data), 32'(fb[NW-1:0]));
        chk("t4_in_ready", 32'(bus0.in_ready), 32'd1);
        drain();

        // asynchronous reset after the third element
        send_frame(FW'($urandom));
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        expq.delete();
        held     = 0;
        done_cnt = 0;
        #1;
        chk("arst_out_valid", 32'(bus0.out_valid), 32'd0);
        chk("arst_frames_done", 32'(bus0.frames_done), 32'd0);
        chk("arst_in_ready", 32'(bus0.in_ready), 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // fresh frame, then 255 more with random backpressure: counter wraps
        send_frame(FW'($urandom));
        chk("fresh_first", 32'(bus0.out_first), 32'd1);
        chk("fresh_idx", 32'({bus0.out_outer_idx, bus0.out_inner_idx}), 32'd0);
        ready_mode = 2;
        for (int n = 1; n < 256; n++) send_frame(FW'($urandom));
        drain();
        ready_mode = 0;
        chk("wrap_done", 32'(bus0.frames_done), 32'd0);

        // single-element geometry
        for (int k = 0; k < 4; k++) begin
            f1 = 4'($urandom);
            bus1.in_frame = f1;
            bus1.in_valid = 1'b1;
            @(posedge clk);
            #1;
            bus1.in_valid = 1'b0;
            chk("u1_valid", 32'(bus1.out_valid), 32'd1);
            chk("u1_data", 32'(bus1.out_data), 32'(f1));
            chk("u1_first", 32'(bus1.out_first), 32'd1);
            chk("u1_last", 32'(bus1.out_last), 32'd1);
            @(posedge clk);
            #1;
            chk("u1_idle", 32'(bus1.out_valid), 32'd0);
            chk("u1_done", 32'(bus1.frames_done), 32'(k + 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
